priority_drain_encoder: RTL and testbench
=========================================

PRIORITY_DRAIN_ENCODER -- requirements
Module: priority_drain_encoder

Interface
REQ-001 Parameter N, default 8, SHALL set the number of request bits (legal range 2..64).
REQ-002 Local parameter W SHALL equal clog2(N) and sets the index width (N=8 gives W=3).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 d  input  N  SHALL be the request vector, sampled only on an accepted load.
REQ-006 load_valid  input  1  SHALL indicate d is offered for capture.
REQ-007 load_ready  output  1  SHALL indicate the block can accept a load.
REQ-008 y  output  W  SHALL be the binary index of the current pending bit.
REQ-009 y_valid  output  1  SHALL indicate y holds a valid index.
REQ-010 y_ready  input  1  SHALL indicate the consumer accepts y this cycle.
REQ-011 busy  output  1  SHALL be high while indices remain to be drained.
REQ-012 done  output  1  SHALL give a one-cycle pulse when a captured vector is fully drained.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and DRAIN.
REQ-014 In IDLE, load_ready SHALL be 1, y_valid SHALL be 0 and busy SHALL be 0.
REQ-015 A load SHALL be accepted when load_valid=1 and load_ready=1 on the same edge, capturing d into the pending register.
REQ-016 If the captured d is nonzero, the next state SHALL be DRAIN, with y_valid=1 on the cycle after acceptance (latency 1).
REQ-017 If the captured d is all zeros, the block SHALL stay in IDLE and pulse done on the cycle after acceptance; y_valid SHALL never assert.
REQ-018 In DRAIN, y SHALL equal the index of the lowest-numbered set bit of pending (bit 0 has the highest priority), y_valid SHALL be 1, load_ready SHALL be 0 and busy SHALL be 1.
REQ-019 A transfer SHALL occur when y_valid=1 and y_ready=1 on the same edge; that bit SHALL then be cleared from pending.
REQ-020 While y_valid=1 and y_ready=0, y SHALL hold stable.
REQ-021 With y_ready held at 1, the block SHALL sustain one index per cycle, giving popcount(d) consecutive transfers.
REQ-022 On the transfer that clears the last set bit, the next state SHALL be IDLE and done SHALL pulse on the following cycle, coincident with load_ready=1.
REQ-023 A load may be accepted on the same cycle done is high.
REQ-024 load_valid asserted in DRAIN SHALL be ignored, and d SHALL NOT be sampled.
REQ-025 y, y_valid, load_ready, busy and done SHALL be driven from registered state only, with no combinational path from d, load_valid or y_ready.
REQ-026 When y_valid=0, y SHALL be 0.

Reset
REQ-027 rst=1 SHALL, at the next edge, force IDLE, pending=0, y=0, y_valid=0, busy=0, done=0 and load_ready=1.
REQ-028 A reset asserted mid-DRAIN SHALL discard all pending bits with no done pulse, and rst SHALL take priority over any simultaneous load or transfer.

Configuration
REQ-029 With macro PRIORITY_DRAIN_COUNT_EN defined, the block SHALL add an output port cnt, clog2(N+1) bits wide, equal to the popcount of pending, registered and updated on the same edge as pending, and reset to 0.
REQ-030 Without PRIORITY_DRAIN_COUNT_EN, the cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Walk test: for N=8, load each of the eight one-hot vectors with y_ready=1 -> one transfer each, y=0..7 respectively, then done.
REQ-032 Multi-bit drain: load d=8'b1010_0110 with y_ready=1 -> y sequence 1,2,5,7 on consecutive cycles, then done one cycle after the last transfer (cnt 4,3,2,1,0 when enabled).
REQ-033 Backpressure: load d=8'b1000_0001 and hold y_ready=0 for 3 cycles -> y stays 0 with y_valid=1, then y_ready=1 -> y=7 next, then done.
REQ-034 Zero load: load d=0 -> y_valid stays 0 and done pulses once on the next cycle.
REQ-035 Reset mid-drain: load 8'hFF, transfer 2 indices, assert rst -> IDLE, y_valid=0 and no done; a fresh load of 8'h10 -> y=4.
REQ-036 Width and back-to-back: with N=16, load 16'h8001, then reload 16'h0100 on the done cycle -> y sequence 0,15,8 with no idle cycle after the reload is accepted.

Source files
------------

// File: rtl/priority_drain_encoder.sv
// priority_drain_encoder: captures a request vector and drains its set bits
// lowest-index first, one binary index per accepted y transfer.
// Ports: clk, rst (sync, active-high); load: d/load_valid/load_ready;
//        drain: y/y_valid/y_ready; status: busy, done (1-cycle pulse).
// Optional macro PRIORITY_DRAIN_COUNT_EN adds cnt = popcount(pending).
// Latency: y_valid rises the cycle after load acceptance; done follows the
// last transfer by one cycle. All outputs come straight from flops.
module priority_drain_encoder #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             d,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic [$clog2(N)-1:0]     y,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic                     busy,
  output logic                     done
`ifdef PRIORITY_DRAIN_COUNT_EN
  ,
  output logic [$clog2(N+1)-1:0]   cnt
`endif
);

  localparam int W = $clog2(N);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   y_q, y_d;
  logic           done_q, done_d;
  logic           load_acc, xfer;

  // Handshakes are qualified by registered state only, so no input reaches
  // an output without passing through a flop.
  assign load_acc = (state_q == IDLE) && load_valid;
  assign xfer     = (state_q == DRAIN) && y_ready;

  always_comb begin
    pend_d  = pend_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (load_acc) begin
      pend_d  = d;
      state_d = (d != '0) ? DRAIN : IDLE;
      done_d  = (d == '0);
    end else if (xfer) begin
      // Clearing the lowest set bit is exactly the bit currently shown on y.
      pend_d  = pend_q & (pend_q - {{(N-1){1'b0}}, 1'b1});
      state_d = (pend_d != '0) ? DRAIN : IDLE;
      done_d  = (pend_d == '0);
    end
  end

  // Index of the lowest set bit of the next pending vector; 0 when empty,
  // which keeps y at 0 whenever y_valid is low.
  always_comb begin
    y_d = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_d[i]) y_d = W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      y_q        <= '0;
      done_q     <= 1'b0;
      y_valid    <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      y_q        <= y_d;
      done_q     <= done_d;
      y_valid    <= (state_d == DRAIN);
      busy       <= (state_d == DRAIN);
      load_ready <= (state_d == IDLE);
    end
  end

  assign y    = y_q;
  assign done = done_q;

`ifdef PRIORITY_DRAIN_COUNT_EN
  logic [$clog2(N+1)-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d = cnt_d + ($clog2(N+1))'(pend_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_priority_drain_encoder.sv
// Directed bench for priority_drain_encoder at N=8 and N=16.
module tb_priority_drain_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N = 8 instance
  logic [7:0] a_d;
  logic       a_load_valid, a_load_ready;
  logic [2:0] a_y;
  logic       a_y_valid, a_y_ready, a_busy, a_done;
`ifdef PRIORITY_DRAIN_COUNT_EN
  logic [3:0] a_cnt;
`endif

  // N = 16 instance
  logic [15:0] b_d;
  logic        b_load_valid, b_load_ready;
  logic [3:0]  b_y;
  logic        b_y_valid, b_y_ready, b_busy, b_done;
`ifdef PRIORITY_DRAIN_COUNT_EN
  logic [4:0]  b_cnt;
`endif

  priority_drain_encoder #(.N(8)) u_dut_a (
    .clk(clk), .rst(rst), .d(a_d), .load_valid(a_load_valid),
    .load_ready(a_load_ready), .y(a_y), .y_valid(a_y_valid),
    .y_ready(a_y_ready), .busy(a_busy), .done(a_done)
`ifdef PRIORITY_DRAIN_COUNT_EN
    , .cnt(a_cnt)
`endif
  );

  priority_drain_encoder #(.N(16)) u_dut_b (
    .clk(clk), .rst(rst), .d(b_d), .load_valid(b_load_valid),
    .load_ready(b_load_ready), .y(b_y), .y_valid(b_y_valid),
    .y_ready(b_y_ready), .busy(b_busy), .done(b_done)
`ifdef PRIORITY_DRAIN_COUNT_EN
    , .cnt(b_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq [4];
    exp_seq = '{1, 2, 5, 7};

    rst = 1'b1;
    a_d = '0; a_load_valid = 1'b0; a_y_ready = 1'b0;
    b_d = '0; b_load_valid = 1'b0; b_y_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_load_ready", a_load_ready, 1);
    check("rst_y_valid",    a_y_valid,    0);
    check("rst_busy",       a_busy,       0);
    check("rst_done",       a_done,       0);
    check("rst_y",          a_y,          0);
`ifdef PRIORITY_DRAIN_COUNT_EN
    check("rst_cnt",        a_cnt,        0);
`endif

    // Walk one-hot vectors
    for (int k = 0; k < 8; k++) begin
      a_d = 8'(1 << k); a_load_valid = 1'b1; a_y_ready = 1'b1;
      step();
      a_load_valid = 1'b0;
      check("walk_y_valid",    a_y_valid,    1);
      check("walk_y",          a_y,          k);
      check("walk_busy",       a_busy,       1);
      check("walk_load_ready", a_load_ready, 0);
      step();
      check("walk_done",       a_done,       1);
      check("walk_y_valid_lo", a_y_valid,    0);
      check("walk_ready_back", a_load_ready, 1);
      step();
      check("walk_done_lo",    a_done,       0);
    end

    // Multi-bit drain 1010_0110
    a_d = 8'hA6; a_load_valid = 1'b1; a_y_ready = 1'b1;
    step();
    a_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("multi_y_valid", a_y_valid, 1);
      check("multi_y",       a_y,       exp_seq[i]);
      check("multi_done_lo", a_done,    0);
`ifdef PRIORITY_DRAIN_COUNT_EN
      check("multi_cnt",     a_cnt,     4 - i);
`endif
      step();
    end
    check("multi_done",    a_done,    1);
    check("multi_y_valid_lo", a_y_valid, 0);
    check("multi_y_zero",  a_y,       0);
`ifdef PRIORITY_DRAIN_COUNT_EN
    check("multi_cnt_end", a_cnt,     0);
`endif
    step();
    check("multi_done_once", a_done, 0);

    // Backpressure, with a load offered during DRAIN that must be ignored
    a_d = 8'h81; a_load_valid = 1'b1; a_y_ready = 1'b0;
    step();
    a_d = 8'h02;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_y",       a_y,       0);
      check("bp_hold_y_valid", a_y_valid, 1);
      step();
    end
    a_load_valid = 1'b0; a_y_ready = 1'b1;
    check("bp_before_xfer", a_y, 0);
    step();
    check("bp_y7",       a_y,       7);
    check("bp_y7_valid", a_y_valid, 1);
    step();
    check("bp_done",     a_done,    1);
    check("bp_ignored_load", a_y_valid, 0);
    step();

    // Zero load
    a_d = 8'h00; a_load_valid = 1'b1;
    step();
    a_load_valid = 1'b0;
    check("zero_y_valid",    a_y_valid,    0);
    check("zero_done",       a_done,       1);
    check("zero_load_ready", a_load_ready, 1);
    step();
    check("zero_done_once",  a_done,       0);
    check("zero_y_valid2",   a_y_valid,    0);

    // Reset mid-drain
    a_d = 8'hFF; a_load_valid = 1'b1; a_y_ready = 1'b1;
    step();
    a_load_valid = 1'b0;
    check("rmd_y0", a_y, 0);
    step();
    check("rmd_y1", a_y, 1);
    step();
    check("rmd_y2", a_y, 2);
    rst = 1'b1; a_load_valid = 1'b1; a_d = 8'h40;
    step();
    rst = 1'b0; a_load_valid = 1'b0;
    check("rmd_y_valid",    a_y_valid,    0);
    check("rmd_done",       a_done,       0);
    check("rmd_load_ready", a_load_ready, 1);
    check("rmd_busy",       a_busy,       0);
    check("rmd_y_zero",     a_y,          0);
`ifdef PRIORITY_DRAIN_COUNT_EN
    check("rmd_cnt",        a_cnt,        0);
`endif
    step();
    check("rmd_no_done",    a_done,       0);
    a_d = 8'h10; a_load_valid = 1'b1;
    step();
    a_load_valid = 1'b0;
    check("rmd_fresh_y",    a_y,          4);
    check("rmd_fresh_vld",  a_y_valid,    1);
    step();
    check("rmd_fresh_done", a_done,       1);
    step();

    // N=16 back-to-back reload on the done cycle
    b_d = 16'h8001; b_load_valid = 1'b1; b_y_ready = 1'b1;
    step();
    b_load_valid = 1'b0;
    check("b_y0", b_y, 0);
    check("b_y0_valid", b_y_valid, 1);
    step();
    check("b_y15", b_y, 15);
    b_d = 16'h0100; b_load_valid = 1'b1;
    step();
    check("b_done",       b_done,       1);
    check("b_load_ready", b_load_ready, 1);
    step();
    b_load_valid = 1'b0;
    check("b_y8",       b_y,       8);
    check("b_y8_valid", b_y_valid, 1);
    check("b_done_lo",  b_done,    0);
    step();
    check("b_done2",    b_done,    1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
